// File: rtl/sweep_controller_pkg.sv
// sweep_controller_pkg: shared constants, mode encodings, state enum and exponent helpers.
//   Holds MAX_EXP, EXP_W, the mode codes (mode 11 runs as single), the IDLE/RUN state
//   type, clamp_exp (limits an exponent to 0..MAX_EXP) and onehot (exponent to 16-bit frequency).
package sg_pkg;
    localparam int EXP_W   = 4;
    localparam int MAX_EXP = 13;
    localparam logic [1:0] MODE_SINGLE   = 2'b00;
    localparam logic [1:0] MODE_WRAP     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    typedef logic [EXP_W-1:0] exp_t;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic exp_t clamp_exp(input exp_t e);
        return (e > EXP_W'(MAX_EXP)) ? EXP_W'(MAX_EXP) : e;
    endfunction
    function automatic logic [15:0] onehot(input exp_t e);
        return 16'd1 << e;
    endfunction
endpackage

// File: rtl/sweep_controller_if.sv
// sweep_controller_if: control and generator-facing signals of the sweep controller.
//   master: drives start/stop pulses and sweep config, observes frequency/gen_on/busy/strobes.
//   slave : the controller side.
import sg_pkg::*;
interface sweep_controller_if #(parameter int DWELL_W = 16);
    logic               start;
    logic               stop;
    exp_t               exp_start;
    exp_t               exp_stop;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         mode;
    logic [15:0]        frequency;
    logic               gen_on;
    logic               busy;
    logic               step_strobe;
    logic               done;
    modport master (output start, stop, exp_start, exp_stop, dwell, mode,
                    input  frequency, gen_on, busy, step_strobe, done);
    modport slave  (input  start, stop, exp_start, exp_stop, dwell, mode,
                    output frequency, gen_on, busy, step_strobe, done);
endinterface

// File: rtl/sweep_controller_tick_prescaler.sv
// tick_prescaler: emits a 1-cycle tick every DIV cycles, phase-aligned to the last clr.
//   clk, rst (sync, active-high), clr (restart count), tick (output pulse).
module tick_prescaler #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    // Tick is decoded from the count so the consumer acts on the DIV-th edge after clr.
    assign tick = (cnt == CW'(DIV - 1));
    always_ff @(posedge clk) begin
        if (rst || clr || tick) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sweep_controller.sv
// sweep_controller: steps signal_generator frequency through powers of two with a programmable dwell.
//   clk, rst (sync, active-high); bus (slave): start/stop pulses, exp_start/exp_stop/dwell/mode config,
//   frequency/gen_on to the generator, busy, step_strobe and done status. All outputs registered.
import sg_pkg::*;
module sweep_controller #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int DWELL_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    sweep_controller_if.slave   bus
);
    state_t             state;
    exp_t               cur, start_l, stop_l, hi, lo, nxt, es, ee;
    logic               up, tick, at_end, finish;
    logic [1:0]         mode_l;
    logic [DWELL_W-1:0] dwell_l, dcnt;
    tick_prescaler #(.DIV(CLK_FREQ_HZ / TICK_HZ)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.start),
        .tick (tick)
    );
    assign es = clamp_exp(bus.exp_start);
    assign ee = clamp_exp(bus.exp_stop);
    assign hi = (start_l > stop_l) ? start_l : stop_l;
    assign lo = (start_l > stop_l) ? stop_l : start_l;
    assign at_end = up ? (cur == hi) : (cur == lo);
    // Ping-pong flips direction at an endpoint and moves immediately; degenerate range holds.
    assign nxt = !at_end                ? (up ? cur + 1'b1 : cur - 1'b1) :
                 mode_l == MODE_WRAP    ? start_l :
                 hi == lo               ? cur :
                 up                     ? cur - 1'b1 : cur + 1'b1;
    assign finish = at_end && mode_l != MODE_WRAP && mode_l != MODE_PINGPONG;
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= '0;
            start_l         <= '0;
            stop_l          <= '0;
            up              <= 1'b1;
            mode_l          <= MODE_SINGLE;
            dwell_l         <= DWELL_W'(1);
            dcnt            <= '0;
            bus.frequency   <= 16'd1;
            bus.gen_on      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.step_strobe <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.step_strobe <= 1'b0;
            bus.done        <= 1'b0;
            if (bus.stop) begin
                state      <= IDLE;
                bus.gen_on <= 1'b0;
                bus.busy   <= 1'b0;
            end else if (bus.start) begin
                state           <= RUN;
                start_l         <= es;
                stop_l          <= ee;
                up              <= (ee >= es);
                mode_l          <= bus.mode;
                dwell_l         <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                dcnt            <= '0;
                cur             <= es;
                bus.frequency   <= onehot(es);
                bus.gen_on      <= 1'b1;
                bus.busy        <= 1'b1;
                bus.step_strobe <= 1'b1;
            end else if (state == RUN && tick) begin
                if (dcnt != dwell_l - 1'b1) begin
                    dcnt <= dcnt + 1'b1;
                end else begin
                    dcnt <= '0;
                    if (finish) begin
                        state      <= IDLE;
                        bus.gen_on <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end else begin
                        if (at_end && mode_l == MODE_PINGPONG) up <= ~up;
                        cur             <= nxt;
                        bus.frequency   <= onehot(nxt);
                        bus.step_strobe <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
